// File: rtl/apb_ram_slave.sv
// APB4 RAM slave: configurable width/depth, byte strobes and wait states.
// Optional error response is enabled by defining APB_RAM_PSLVERR_EN.
module apb_ram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

`ifdef APB_RAM_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     strb_q, strb_d;
    logic              err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic setup, load, done, addr_err, err_act;

    assign setup    = psel & ~penable;
    assign load     = setup & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign done     = (state_q == S_DONE) & psel & penable;
    // Out of range above the index field, or not aligned to a full word.
    assign addr_err = ((paddr >> (LSB + IDX_W)) != '0) || ((paddr & LOW_MASK) != '0);
    assign err_act  = err_q & ERR_EN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            idx_d   = paddr[LSB +: IDX_W];
            wr_d    = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
            err_d   = addr_err;
            cnt_d   = 4'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    // Read is captured at setup; any earlier write has already committed in its DONE cycle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)    rdata_q <= '0;
        else if (load) rdata_q <= mem[paddr[LSB +: IDX_W]];
    end

    always_ff @(posedge pclk) begin
        if (done && wr_q && !err_act) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign pready  = done;
    assign pslverr = done & err_act;
    assign prdata  = (done && !wr_q && !err_act) ? rdata_q : '0;

endmodule

// File: doc/apb_ram_slave.md
# apb_ram_slave

Parametrised APB4 memory-mapped RAM slave, next-generation successor to the fixed 32-bit APB RAM target. Adds configurable data/address width and depth, byte-lane write strobes, programmable wait states and error response. Sits behind the APB bus interface as the memory endpoint used by the APB_RAM environment.

## Interface

- ADDR_WIDTH, 32: width of paddr (byte address).
- DATA_WIDTH, 32: width of pwdata/prdata; legal values are 8, 16, 32 and 64.
- DEPTH, 64: number of DATA_WIDTH words; must be a power of two, at least 2.
- WAIT_STATES, 0: pready-low cycles inserted in each access phase; range 0..15.
- pclk  in  1  bus clock; all logic on its rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte-lane write enables.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1 on a read.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; valid only while pready=1.

## Operation

- Word index = paddr[LSB+log2(DEPTH)-1 : LSB], where LSB = log2(DATA_WIDTH/8).
- Registered FSM with states IDLE, WAIT and DONE.
- IDLE: on psel=1 and penable=0 (setup phase), latch paddr, pwrite, pwdata and pstrb. Load wait counter with WAIT_STATES. Go to WAIT, or go directly to DONE if WAIT_STATES=0.
- WAIT: decrement counter each cycle; when counter reaches 1, go to DONE.
- DONE: pready=1 for exactly one cycle.
  - Write: each byte lane i with pstrb[i]=1 is updated; other lanes are unchanged. pstrb=0 is a legal no-op that still completes.
  - Read: prdata = stored word. prdata is driven from the registered read of the latched index.
  - After DONE: if psel=1 and penable=0, treat as a back-to-back setup and reload. Otherwise go to IDLE.
- psel=0 while in WAIT or DONE (protocol abort): go to IDLE. No write occurs, pready stays 0.
- prdata holds 0 except in DONE for a read.
- pslverr is 0 except in DONE.
- Memory contents are not reset. Reads before any write return X in simulation.

## Timing

- Reset values: pready=0, pslverr=0, prdata=0, FSM=IDLE, counter=0.
- Assertion of preset mid-transfer forces IDLE immediately. A pending write is dropped and memory is untouched.
- Latency from setup cycle (cycle 0) to pready=1 is 1+WAIT_STATES cycles:
  - WAIT_STATES=0 gives zero-wait APB: pready is high in the first access cycle.
  - WAIT_STATES=3 gives pready high in the 4th access cycle.
- Write data is visible to a read issued immediately after it (read-after-write through memory; no bypass needed since the write commits in DONE).
- Back-to-back transfers sustain one transfer per 2+WAIT_STATES cycles.

## Configuration

- APB_RAM_PSLVERR_EN defined:
  - pslverr=1 in DONE when the paddr upper bits above the index are non-zero (out of range), or when paddr[LSB-1:0] != 0 (misaligned).
  - Erroring writes do not modify memory.
  - Erroring reads return prdata=0.
- APB_RAM_PSLVERR_EN undefined:
  - pslverr is tied to 0.
  - Upper and low address bits are ignored; the index wraps modulo DEPTH.
  - All accesses complete normally.

## Test plan

- Reset, then zero-wait writes: WAIT_STATES=0; write 0xDEADBEEF to 0x04 with pstrb=0xF, then read 0x04. Required: prdata=0xDEADBEEF, pready high in the first access cycle, pslverr=0.
- Byte strobes: write 0x11223344 to 0x08, then write 0xAABBCCDD with pstrb=0x5, then read 0x08. Required: 0x11BB33DD.
- Wait states: WAIT_STATES=3; read 0x0C. Required: pready low for 3 access cycles, high on the 4th with correct data; cycle counts matched for writes.
- Errors (macro defined, DEPTH=64): write to 0x100 and read from 0x02. Required: pslverr=1 in the pready cycle, memory unchanged, prdata=0. With the macro undefined, 0x100 aliases word 0.
- Abort and reset: deassert psel during WAIT, and separately assert preset during WAIT of a write to 0x10. Required: FSM returns to IDLE, pready never asserted, a later read of 0x10 returns the prior value.
- Back-to-back: 16 alternating write/read transfers with no idle cycles between them. Required: every read matches its preceding write, throughput one transfer per 2+WAIT_STATES cycles.
